// File: rtl/vga_pkg.sv
// Shared types and default geometry for the VGA pixel path.
package vga_pkg;

    typedef logic [23:0] pixel_t;

    typedef enum logic [1:0] {
        S_SYNC,
        S_FILL,
        S_STREAM
    } feeder_state_t;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

endpackage

// File: rtl/pixel_fifo.sv
// Show-ahead pixel FIFO; head is valid whenever not empty.
// Flush empties it, and a push in the flush cycle becomes the sole entry.
module pixel_fifo
    import vga_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [23:0]              din_i,
    output logic [23:0]              head_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    pixel_t          mem_q [DEPTH];
    logic [AW-1:0]   wptr_q;
    logic [AW-1:0]   rptr_q;
    logic [LW-1:0]   level_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else if (flush_i) begin
            rptr_q  <= '0;
            wptr_q  <= push_i ? AW'(1) : AW'(0);
            level_q <= push_i ? LW'(1) : LW'(0);
        end else begin
            if (push_i) wptr_q <= wptr_q + AW'(1);
            if (pop_i)  rptr_q <= rptr_q + AW'(1);
            case ({push_i, pop_i})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_i) mem_q[flush_i ? AW'(0) : wptr_q] <= din_i;
    end

    assign head_o  = mem_q[rptr_q];
    assign level_o = level_q;
    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == LW'(0));

endmodule

// File: rtl/vga_pixel_feeder.sv
// Buffers producer pixels, aligns SOF to vsync and serves one pixel per request (1-cycle latency).
// o_ready drops only when the FIFO is full; words are swallowed while hunting for SOF.
module vga_pixel_feeder
    import vga_pkg::*;
#(
    parameter int     DEPTH      = 16,
    parameter int     H_ACTIVE   = H_ACTIVE_DEF,
    parameter int     V_ACTIVE   = V_ACTIVE_DEF,
    parameter int     PRIME      = DEPTH / 2,
    parameter pixel_t FILL_COLOR = 24'h000000
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [23:0]             i_pixel,
    input  logic                    i_valid,
    input  logic                    i_sof,
    output logic                    o_ready,
    input  logic                    i_vsync_n,
    input  logic                    i_request,
    output logic [23:0]             o_color,
    output logic                    o_underflow,
    output logic                    o_frame_err,
    output logic [$clog2(DEPTH):0]  o_level
);
    localparam int TOTAL = H_ACTIVE * V_ACTIVE;
    localparam int CW    = $clog2(TOTAL);
    localparam int LW    = $clog2(DEPTH) + 1;

    feeder_state_t  state_q;
    logic           vs_q;
    logic [CW-1:0]  cnt_q;
    logic           need_sof_q;
    pixel_t         color_q;
    logic           underflow_q;
    logic           frame_err_q;

    logic           push, pop, flush;
    logic           full, empty;
    pixel_t         head;
    logic [LW-1:0]  level;
    logic           xfer, vs_fall, frame_end, early_sof, bad_first;

    assign o_ready   = (state_q == S_SYNC) || !full;
    assign xfer      = i_valid && o_ready;
    assign vs_fall   = vs_q && !i_vsync_n;
    assign frame_end = (state_q == S_STREAM) && i_request && (cnt_q == CW'(TOTAL - 1));
    assign early_sof = (state_q == S_STREAM) && xfer && i_sof && !frame_end;
    // The word following a completed frame must open the next one.
    assign bad_first = xfer && !i_sof &&
                       (((state_q == S_FILL) && need_sof_q) || frame_end);

    always_comb begin
        push  = 1'b0;
        pop   = 1'b0;
        flush = 1'b0;
        case (state_q)
            S_SYNC:   push = xfer && i_sof;
            S_FILL: begin
                flush = bad_first;
                push  = xfer && !bad_first;
            end
            S_STREAM: begin
                if (early_sof) begin
                    flush = 1'b1;
                    push  = 1'b1;
                end else begin
                    pop   = i_request && !empty;
                    flush = bad_first;
                    push  = xfer && !bad_first;
                end
            end
            default: ;
        endcase
    end

    pixel_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush),
        .din_i   (i_pixel),
        .head_o  (head),
        .level_o (level),
        .full_o  (full),
        .empty_o (empty)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_SYNC;
            vs_q        <= 1'b1;
            cnt_q       <= '0;
            need_sof_q  <= 1'b0;
            color_q     <= '0;
            underflow_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            vs_q        <= i_vsync_n;
            underflow_q <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                S_SYNC: begin
                    if (xfer && i_sof) begin
                        state_q    <= S_FILL;
                        need_sof_q <= 1'b0;
                    end
                end
                S_FILL: begin
                    if (bad_first) begin
                        frame_err_q <= 1'b1;
                        need_sof_q  <= 1'b0;
                        state_q     <= S_SYNC;
                    end else begin
                        if (xfer) need_sof_q <= 1'b0;
                        if (vs_fall && (level >= LW'(PRIME))) begin
                            state_q <= S_STREAM;
                            cnt_q   <= '0;
                        end
                    end
                end
                S_STREAM: begin
                    if (early_sof) begin
                        frame_err_q <= 1'b1;
                        need_sof_q  <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= S_FILL;
                    end else if (i_request) begin
                        color_q     <= empty ? FILL_COLOR : head;
                        underflow_q <= empty;
                        if (frame_end) begin
                            cnt_q <= '0;
                            if (bad_first) begin
                                frame_err_q <= 1'b1;
                                state_q     <= S_SYNC;
                            end else begin
                                need_sof_q <= !xfer;
                                state_q    <= S_FILL;
                            end
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                default: state_q <= S_SYNC;
            endcase
        end
    end

    assign o_color     = color_q;
    assign o_underflow = underflow_q;
    assign o_frame_err = frame_err_q;
    assign o_level     = level;

endmodule

// File: tb/tb_vga_pixel_feeder.sv
// Bench for vga_pixel_feeder: queue-based reference model checked every cycle plus directed literal checks.
module tb_vga_pixel_feeder;
    localparam int          DEPTH = 4;
    localparam int          HA    = 4;
    localparam int          VA    = 2;
    localparam int          PRIME = 2;
    localparam logic [23:0] FILLC = 24'h000000;
    localparam int          TOTAL = HA * VA;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] i_pixel;
    logic        i_valid, i_sof, i_vsync_n, i_request;
    logic        o_ready, o_underflow, o_frame_err;
    logic [23:0] o_color;
    logic [2:0]  o_level;

    int n_tests = 0;
    int n_fail  = 0;

    vga_pixel_feeder #(
        .DEPTH(DEPTH), .H_ACTIVE(HA), .V_ACTIVE(VA), .PRIME(PRIME), .FILL_COLOR(FILLC)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_pixel(i_pixel), .i_valid(i_valid), .i_sof(i_sof),
        .o_ready(o_ready), .i_vsync_n(i_vsync_n), .i_request(i_request), .o_color(o_color),
        .o_underflow(o_underflow), .o_frame_err(o_frame_err), .o_level(o_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: 0 = hunting SOF, 1 = filling, 2 = streaming
    int          mst, mcnt, osz;
    logic [23:0] mq[$];
    bit          mneed, mvsq, mund, merr, xf, vsf, fend;
    logic [23:0] mcolor;

    function automatic bit mready();
        return (mst == 0) || (mq.size() < DEPTH);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mst = 0; mq.delete(); mcnt = 0; mneed = 0; mvsq = 1;
            mcolor = 0; mund = 0; merr = 0;
        end else begin
            xf   = i_valid && mready();
            vsf  = mvsq && !i_vsync_n;
            mvsq = i_vsync_n;
            mund = 0; merr = 0;
            osz  = mq.size();
            if (mst == 0) begin
                if (xf && i_sof) begin mq.delete(); mq.push_back(i_pixel); mst = 1; mneed = 0; end
            end else if (mst == 1) begin
                if (xf && mneed && !i_sof) begin
                    merr = 1; mq.delete(); mst = 0; mneed = 0;
                end else begin
                    if (xf) begin mq.push_back(i_pixel); mneed = 0; end
                    if (vsf && osz >= PRIME) begin mst = 2; mcnt = 0; end
                end
            end else begin
                fend = i_request && (mcnt == TOTAL - 1);
                if (xf && i_sof && !fend) begin
                    merr = 1; mq.delete(); mq.push_back(i_pixel); mst = 1; mcnt = 0; mneed = 0;
                end else begin
                    if (i_request) begin
                        if (osz > 0) mcolor = mq.pop_front();
                        else begin mcolor = FILLC; mund = 1; end
                        mcnt++;
                    end
                    if (fend) begin
                        mcnt = 0;
                        if (xf && !i_sof) begin merr = 1; mq.delete(); mst = 0; end
                        else begin
                            if (xf) mq.push_back(i_pixel);
                            mst = 1; mneed = !xf;
                        end
                    end else if (xf) mq.push_back(i_pixel);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("cmp_color", o_color, mcolor);
            chk("cmp_underflow", o_underflow, mund);
            chk("cmp_frame_err", o_frame_err, merr);
            chk("cmp_level", o_level, mq.size());
            chk("cmp_ready", o_ready, mready());
        end
    end

    task automatic step(input logic v, input logic s, input logic [23:0] p, input logic r);
        i_valid = v; i_sof = s; i_pixel = p; i_request = r;
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 24'h0, 1'b0);
    endtask

    task automatic vs_pulse();
        i_vsync_n = 1'b0;
        idle();
        i_vsync_n = 1'b1;
    endtask

    task automatic reset_dut();
        i_valid = 0; i_sof = 0; i_request = 0; i_pixel = 0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [23:0] exp4 [4];
    int          und_cnt;

    initial begin
        rst_n = 1'b0; i_valid = 0; i_sof = 0; i_pixel = 0; i_request = 0; i_vsync_n = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_color", o_color, 24'h0);
        chk("rst_underflow", o_underflow, 0);
        chk("rst_frame_err", o_frame_err, 0);
        chk("rst_level", o_level, 0);
        chk("rst_ready", o_ready, 1);

        // Words without SOF are swallowed while hunting
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 24'h0A0000 + 24'(i), 1'b0);
        idle();
        chk("t1_level", o_level, 0);
        chk("t1_ready", o_ready, 1);
        chk("t1_color", o_color, 24'h0);

        // Basic stream, one pixel per request with one-cycle latency
        exp4[0] = 24'hAA0001; exp4[1] = 24'hBB0002; exp4[2] = 24'hCC0003; exp4[3] = 24'hDD0004;
        step(1'b1, 1'b1, exp4[0], 1'b0);
        for (int i = 1; i < 4; i++) step(1'b1, 1'b0, exp4[i], 1'b0);
        idle();
        chk("t2_level_full", o_level, 4);
        chk("t2_ready_full", o_ready, 0);
        vs_pulse();
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 24'h0, 1'b1);
            chk("t2_color", o_color, exp4[i]);
            chk("t2_no_underflow", o_underflow, 0);
        end
        idle();
        chk("t2_level_empty", o_level, 0);

        // Underflow: 8 requests, only 6 words ever supplied
        reset_dut();
        step(1'b1, 1'b1, 24'h300000, 1'b0);
        step(1'b1, 1'b0, 24'h300001, 1'b0);
        idle();
        vs_pulse();
        und_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step(i < 4, 1'b0, 24'h300002 + 24'(i), 1'b1);
            chk("t3_color", o_color, (i < 6) ? 24'h300000 + 24'(i) : 24'h000000);
            und_cnt += int'(o_underflow);
        end
        chk("t3_underflow_count", und_cnt, 2);
        step(1'b0, 1'b0, 24'h0, 1'b1);
        chk("t3_req_ignored", o_underflow, 0);
        step(1'b1, 1'b0, 24'h3000FF, 1'b0);
        chk("t3_missing_sof_err", o_frame_err, 1);
        chk("t3_missing_sof_level", o_level, 0);
        idle();
        chk("t3_err_one_cycle", o_frame_err, 0);

        // Full FIFO backpressure and simultaneous push/pop
        reset_dut();
        step(1'b1, 1'b1, 24'h400001, 1'b0);
        for (int i = 2; i <= 4; i++) step(1'b1, 1'b0, 24'h400000 + 24'(i), 1'b0);
        idle();
        chk("t4_ready_full", o_ready, 0);
        vs_pulse();
        step(1'b1, 1'b0, 24'h400005, 1'b1);
        chk("t4_pop_from_full", o_color, 24'h400001);
        chk("t4_level_3", o_level, 3);
        step(1'b1, 1'b0, 24'h400005, 1'b0);
        chk("t4_refill", o_level, 4);
        step(1'b1, 1'b0, 24'h400006, 1'b1);
        step(1'b1, 1'b0, 24'h400006, 1'b1);
        chk("t4_push_pop_level", o_level, 3);
        chk("t4_push_pop_color", o_color, 24'h400003);
        for (int i = 4; i <= 6; i++) begin
            step(1'b0, 1'b0, 24'h0, 1'b1);
            chk("t4_order", o_color, 24'h400000 + 24'(i));
        end

        // Early SOF, skipped vsync with low level, then mid-stream reset
        reset_dut();
        step(1'b1, 1'b1, 24'h500001, 1'b0);
        for (int i = 2; i <= 4; i++) step(1'b1, 1'b0, 24'h500000 + 24'(i), 1'b0);
        idle();
        vs_pulse();
        for (int i = 1; i <= 3; i++) step(1'b0, 1'b0, 24'h0, 1'b1);
        chk("t5_color_c", o_color, 24'h500003);
        step(1'b1, 1'b1, 24'h5000EE, 1'b1);
        chk("t5_early_sof_err", o_frame_err, 1);
        chk("t5_early_sof_level", o_level, 1);
        chk("t5_pop_cancelled", o_color, 24'h500003);
        step(1'b0, 1'b0, 24'h0, 1'b1);
        chk("t5_fill_ignores_req", o_color, 24'h500003);
        vs_pulse();
        step(1'b0, 1'b0, 24'h0, 1'b1);
        chk("t6_low_prime_skip", o_color, 24'h500003);
        chk("t6_low_prime_level", o_level, 1);
        step(1'b1, 1'b0, 24'h500006, 1'b0);
        idle();
        vs_pulse();
        step(1'b0, 1'b0, 24'h0, 1'b1);
        chk("t6_stream_starts_e", o_color, 24'h5000EE);
        step(1'b1, 1'b0, 24'h500007, 1'b1);
        chk("t6_second_pixel", o_color, 24'h500006);
        chk("t6_level_before_rst", o_level, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_color", o_color, 24'h0);
        chk("t6_async_level", o_level, 0);
        chk("t6_async_underflow", o_underflow, 0);
        chk("t6_async_frame_err", o_frame_err, 0);
        i_valid = 0; i_request = 0; i_sof = 0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 24'h500008, 1'b0);
        chk("t6_resync_drop", o_level, 0);
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
